// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encoding
// and the operation-select values carried on the sub input.
package serial_addsub_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa.sv
// Single full-adder cell; the only arithmetic in the bit-serial datapath.
module full_add_s (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one full-adder cell and a carry flop.
// start/busy: a request is taken on any rising edge where busy=0 and start=1;
// there is no backpressure beyond busy, and requests while busy are dropped.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  full_add_s u_fa (
    .x (a_q[0]),
    .y (b_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        // Subtraction runs as a + ~b + 1: invert B and seed the carry with 1.
        state_d = ST_RUN;
        a_d     = a;
        b_d     = (sub == OP_SUB) ? ~b : b;
        carry_d = sub;
        cnt_d   = '0;
      end
    end else begin
      result_d = {fa_s, result_q[WIDTH-1:1]};
      a_d      = {1'b0, a_q[WIDTH-1:1]};
      b_d      = {1'b0, b_q[WIDTH-1:1]};
      carry_d  = fa_c;
      if (cnt_q == CNT_LAST) begin
        // On the MSB, carry_q is the carry into the MSB and fa_c the carry out.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        cout_d  = fa_c;
        ovf_d   = carry_q ^ fa_c;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH=4: directed cases, busy/reset handling,
// random single operations and an exhaustive back-to-back sweep.
module tb_serial_addsub;

  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int LAT = W;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W+1:0] exp_q[$];

  serial_addsub #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout, ovf, result} from plain integer arithmetic.
  function automatic logic [W+1:0] ref_model(input int av, input int bv, input logic s);
    int sa, sb, sr, u;
    logic c, o;
    logic [W-1:0] r;
    sa = (av >= MOD / 2) ? av - MOD : av;
    sb = (bv >= MOD / 2) ? bv - MOD : bv;
    sr = s ? sa - sb : sa + sb;
    u  = s ? av + (MOD - bv) : av + bv;
    c  = (u >= MOD);
    o  = (sr < -(MOD / 2)) || (sr > MOD / 2 - 1);
    r  = W'(u % MOD);
    return {c, o, r};
  endfunction

  // driver tasks
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    @(negedge clk);
    a = av; b = bv; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic s);
    logic [W+1:0] exp;
    int cyc;
    exp = ref_model(int'(av), int'(bv), s);
    issue(av, bv, s);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
    else n_pass++;
    wait_done(cyc);
    n_checks++;
    if (cyc !== LAT) $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
    else n_pass++;
    n_checks++;
    if ({cout, ovf, result} !== exp)
      $display("FAIL %s result: got c=%b o=%b r=%b want c=%b o=%b r=%b",
               name, cout, ovf, result, exp[W+1], exp[W], exp[W-1:0]);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || {cout, ovf, result} !== exp)
      $display("FAIL %s hold_after_done: got done=%b c=%b o=%b r=%b want done=0 c=%b o=%b r=%b",
               name, done, cout, ovf, result, exp[W+1], exp[W], exp[W-1:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, cout, ovf, result} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b c=%b o=%b r=%b want all 0",
               busy, done, cout, ovf, result);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy=%b done=%b want 00", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    check_op("add_3_5", 4'd3, 4'd5, 1'b0);
    n_checks++;
    if ({cout, ovf, result} !== 6'b01_1000) $display("FAIL add_3_5_const: got %b want 011000", {cout, ovf, result});
    else n_pass++;
    check_op("sub_7_2", 4'd7, 4'd2, 1'b1);
    n_checks++;
    if ({cout, ovf, result} !== 6'b10_0101) $display("FAIL sub_7_2_const: got %b want 100101", {cout, ovf, result});
    else n_pass++;
    check_op("sub_2_7", 4'd2, 4'd7, 1'b1);
    n_checks++;
    if ({cout, ovf, result} !== 6'b00_1011) $display("FAIL sub_2_7_const: got %b want 001011", {cout, ovf, result});
    else n_pass++;
    check_op("add_15_1", 4'd15, 4'd1, 1'b0);
    n_checks++;
    if ({cout, ovf, result} !== 6'b10_0000) $display("FAIL add_15_1_const: got %b want 100000", {cout, ovf, result});
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int cyc;
    issue(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc !== LAT - 2) $display("FAIL busy_ignore_latency: got %0d want %0d", cyc, LAT - 2);
    else n_pass++;
    n_checks++;
    if ({cout, ovf, result} !== 6'b01_1000)
      $display("FAIL busy_ignore_result: got %b want 011000", {cout, ovf, result});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_ignore_no_queue: got busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    issue(4'd3, 4'd5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, cout, ovf, result} !== '0)
      $display("FAIL reset_mid_run: got busy=%b done=%b c=%b o=%b r=%b want all 0",
               busy, done, cout, ovf, result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) $display("FAIL reset_no_done: got %0d active cycles want 0", seen_done);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_op("random", W'($urandom_range(0, MOD - 1)), W'($urandom_range(0, MOD - 1)),
               1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    int n_ops, n_done, last_done, cyc_ctr, errs_gap, errs_val;
    logic [W+1:0] exp;
    n_ops = 2 * MOD * MOD;
    n_done = 0; last_done = -1; cyc_ctr = 0; errs_gap = 0; errs_val = 0;
    @(negedge clk);
    fork
      begin : driver
        for (int i = 0; i < n_ops; i++) begin
          int guard;
          guard = 0;
          while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
          end
          a = W'(i % MOD); b = W'((i / MOD) % MOD); sub = 1'(i / (MOD * MOD));
          start = 1'b1;
          exp_q.push_back(ref_model(int'(a), int'(b), sub));
          @(negedge clk);
        end
        start = 1'b0;
      end
      begin : monitor
        while (n_done < n_ops && cyc_ctr < n_ops * (W + 1) + 50) begin
          @(negedge clk);
          #1;
          cyc_ctr++;
          if (done) begin
            if (last_done >= 0 && cyc_ctr - last_done != W + 1) errs_gap++;
            last_done = cyc_ctr;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if ({cout, ovf, result} !== exp) begin
              errs_val++;
              $display("FAIL b2b_result op%0d: got c=%b o=%b r=%b want c=%b o=%b r=%b",
                       n_done, cout, ovf, result, exp[W+1], exp[W], exp[W-1:0]);
            end else n_pass++;
            n_done++;
          end
        end
      end
    join
    n_checks++;
    if (n_done !== n_ops) $display("FAIL b2b_count: got %0d dones want %0d", n_done, n_ops);
    else n_pass++;
    n_checks++;
    if (errs_gap !== 0) $display("FAIL b2b_spacing: got %0d bad gaps want 0", errs_gap);
    else n_pass++;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
